sync_frame_parser: RTL and testbench

SYNC_FRAME_PARSER -- requirements
Module: sync_frame_parser

---
 rtl/sync_frame_pkg.sv | 23 ++
 rtl/sfp_out_reg.sv | 45 ++++
 rtl/sync_frame_parser.sv | 126 ++++++++++++
 tb/tb_sync_frame_parser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync-byte framed stream parser.
package sync_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT0,
    ST_HUNT1,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_W       = 16;
  localparam logic [7:0]  SYNC0_DEF   = 8'h55;
  localparam logic [7:0]  SYNC1_DEF   = 8'hAA;
  localparam logic [7:0]  MAX_LEN_DEF = 8'd64;

  // Saturating increment for the frame statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sfp_out_reg.sv
// Single-entry payload holding register with valid/ready handshake.
module sfp_out_reg
  import sync_frame_pkg::*;
(
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_sop,
  output logic              o_eop
);

  logic              r_valid;
  logic [BYTE_W-1:0] r_data;
  logic              r_sop;
  logic              r_eop;

  // A load wins over a drain so back-to-back beats keep valid high.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;

endmodule

// File: rtl/sync_frame_parser.sv
// Hunts SYNC0/SYNC1, reads a length byte, forwards the payload and checks
// the trailing XOR checksum, reporting per-frame status and counts.
module sync_frame_parser
  import sync_frame_pkg::*;
#(
  parameter logic [7:0] SYNC0   = SYNC0_DEF,
  parameter logic [7:0] SYNC1   = SYNC1_DEF,
  parameter logic [7:0] MAX_LEN = MAX_LEN_DEF
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  output logic             in_rd_en,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           r_state;
  logic [7:0]       r_len;
  logic [7:0]       r_remaining;
  logic [7:0]       r_csum;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_xfer;
  logic w_load;
  logic w_sop;
  logic w_eop;

  // Header/trailer bytes always drain; payload pops only when the holding slot frees up.
  assign in_rd_en = (r_state == ST_PAYLOAD) ? (~m_valid | m_ready) : 1'b1;
  assign w_xfer   = in_vld & in_rd_en;
  assign w_load   = w_xfer & (r_state == ST_PAYLOAD);
  assign w_sop    = (r_remaining == r_len);
  assign w_eop    = (r_remaining == 8'd1);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state     <= ST_HUNT0;
      r_len       <= '0;
      r_remaining <= '0;
      r_csum      <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          ST_HUNT0: begin
            if (in_data == SYNC0) r_state <= ST_HUNT1;
          end
          ST_HUNT1: begin
            if (in_data == SYNC1)      r_state <= ST_LEN;
            else if (in_data != SYNC0) r_state <= ST_HUNT0;
          end
          ST_LEN: begin
            r_len       <= in_data;
            r_remaining <= in_data;
            r_csum      <= in_data;
            if (in_data == 8'd0) begin
              r_state <= ST_CSUM;
            end else if (in_data > MAX_LEN) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_HUNT0;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_csum      <= r_csum ^ in_data;
            r_remaining <= r_remaining - 8'd1;
            if (w_eop) r_state <= ST_CSUM;
          end
          ST_CSUM: begin
            r_frame_ok  <= (in_data == r_csum);
            r_frame_err <= (in_data != r_csum);
            r_state     <= ST_HUNT0;
          end
          default: r_state <= ST_HUNT0;
        endcase
      end
    end
  end

  // Frame statistics, advanced by the registered status pulses.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_frame_ok)  r_ok_cnt  <= sat_inc(r_ok_cnt);
      if (r_frame_err) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign ok_cnt    = r_ok_cnt;
  assign err_cnt   = r_err_cnt;

  sfp_out_reg u_out_reg (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .i_load  (w_load),
    .i_data  (in_data),
    .i_sop   (w_sop),
    .i_eop   (w_eop),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_sop   (m_sop),
    .o_eop   (m_eop)
  );

endmodule

// File: tb/tb_sync_frame_parser.sv
// Directed bench for sync_frame_parser with hand-computed frames and checksums.
module tb_sync_frame_parser;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_vld = 1'b0;
  logic        in_rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sop;
  logic        m_eop;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ready_tog = 1'b0;
  logic       in_pay = 1'b0;
  logic [9:0] beat_q[$];
  int         beat_cyc[$];
  int         cyc = 0;
  int         ok_pulses = 0;
  int         err_pulses = 0;
  int         stall_viol = 0;
  int         hold_viol = 0;
  logic       held = 1'b0;
  logic [9:0] held_v = '0;

  sync_frame_parser dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_rd_en  (in_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    #1;
    m_ready = ready_tog ? ~m_ready : 1'b1;
  end

  // Mid-cycle monitor: records accepted beats, status pulses and handshake rule breaks.
  always @(negedge rd_clk) begin
    cyc = cyc + 1;
    if (rd_rst) begin
      held = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        beat_q.push_back({m_sop, m_eop, m_data});
        beat_cyc.push_back(cyc);
      end
      if (frame_ok)  ok_pulses  = ok_pulses + 1;
      if (frame_err) err_pulses = err_pulses + 1;
      if (in_pay && m_valid && !m_ready && in_rd_en) stall_viol = stall_viol + 1;
      if (held && (!m_valid || ({m_sop, m_eop, m_data} !== held_v))) hold_viol = hold_viol + 1;
      held   = m_valid & ~m_ready;
      held_v = {m_sop, m_eop, m_data};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte after `gap` idle cycles; returns 1ns after the edge that took it.
  task automatic push(input logic [7:0] b, input int gap);
    int  t;
    logic done;
    for (int g = 0; g < gap; g++) begin
      in_vld = 1'b0;
      @(posedge rd_clk); #1;
    end
    in_data = b;
    in_vld  = 1'b1;
    t    = 0;
    done = 1'b0;
    while (!done && t < 200) begin
      @(negedge rd_clk);
      if (in_rd_en) done = 1'b1;
      @(posedge rd_clk); #1;
      t = t + 1;
    end
    if (!done) chk("push_timeout", 32'd0, 32'd1);
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk); #1;
    end
  endtask

  int nb;
  int ok0;
  int err0;

  initial begin
    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    chk("rst_m_valid",  32'(m_valid),   32'd0);
    chk("rst_m_data",   32'(m_data),    32'd0);
    chk("rst_in_rd_en", 32'(in_rd_en),  32'd1);
    chk("rst_frame_ok", 32'(frame_ok),  32'd0);
    chk("rst_ok_cnt",   32'(ok_cnt),    32'd0);
    chk("rst_err_cnt",  32'(err_cnt),   32'd0);
    idle(2);

    // Good 3-byte frame, full throughput.
    nb = beat_q.size(); ok0 = ok_pulses; err0 = err_pulses;
    push(8'h55, 0); push(8'hAA, 0); push(8'h03, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h03, 0);
    chk("f1_ok_pulse", 32'(frame_ok), 32'd1);
    idle(4);
    chk("f1_beats",  32'(beat_q.size() - nb), 32'd3);
    chk("f1_b0",     32'(beat_q[nb]),     32'h211);
    chk("f1_b1",     32'(beat_q[nb+1]),   32'h022);
    chk("f1_b2",     32'(beat_q[nb+2]),   32'h133);
    chk("f1_cyc01",  32'(beat_cyc[nb+1] - beat_cyc[nb]),   32'd1);
    chk("f1_cyc12",  32'(beat_cyc[nb+2] - beat_cyc[nb+1]), 32'd1);
    chk("f1_okp",    32'(ok_pulses - ok0),   32'd1);
    chk("f1_errp",   32'(err_pulses - err0), 32'd0);
    chk("f1_ok_cnt", 32'(ok_cnt), 32'd1);

    // Same frame, bad checksum.
    nb = beat_q.size(); ok0 = ok_pulses; err0 = err_pulses;
    push(8'h55, 0); push(8'hAA, 0); push(8'h03, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h04, 0);
    chk("f2_err_pulse", 32'(frame_err), 32'd1);
    idle(4);
    chk("f2_beats",   32'(beat_q.size() - nb), 32'd3);
    chk("f2_errp",    32'(err_pulses - err0), 32'd1);
    chk("f2_okp",     32'(ok_pulses - ok0),   32'd0);
    chk("f2_err_cnt", 32'(err_cnt), 32'd1);
    chk("f2_ok_cnt",  32'(ok_cnt),  32'd1);

    // Garbage then a zero-length frame.
    nb = beat_q.size(); ok0 = ok_pulses;
    push(8'h00, 0); push(8'h55, 1); push(8'h55, 0);
    push(8'hAA, 0); push(8'h00, 0); push(8'h00, 0);
    chk("f3_ok_pulse", 32'(frame_ok), 32'd1);
    idle(4);
    chk("f3_beats",  32'(beat_q.size() - nb), 32'd0);
    chk("f3_okp",    32'(ok_pulses - ok0), 32'd1);
    chk("f3_ok_cnt", 32'(ok_cnt), 32'd2);

    // Oversize length, then a single-byte frame (01 ^ 7E = 7F).
    nb = beat_q.size();
    push(8'h55, 0); push(8'hAA, 0); push(8'h41, 0);
    chk("f4_len_err", 32'(frame_err), 32'd1);
    push(8'h55, 0); push(8'hAA, 0); push(8'h01, 0);
    push(8'h7E, 0); push(8'h7F, 0);
    chk("f4_ok_pulse", 32'(frame_ok), 32'd1);
    idle(4);
    chk("f4_beats",   32'(beat_q.size() - nb), 32'd1);
    chk("f4_b0",      32'(beat_q[nb]), 32'h37E);
    chk("f4_err_cnt", 32'(err_cnt), 32'd2);
    chk("f4_ok_cnt",  32'(ok_cnt),  32'd3);

    // len=8 with toggling m_ready and upstream gaps; csum = 08^01^..^08 = 00.
    nb = beat_q.size(); ok0 = ok_pulses;
    ready_tog = 1'b1;
    push(8'h55, 0); push(8'hAA, 0); push(8'h08, 0);
    in_pay = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i + 1), i % 3);
    in_pay = 1'b0;
    push(8'h00, 1);
    chk("f5_ok_pulse", 32'(frame_ok), 32'd1);
    ready_tog = 1'b0;
    idle(6);
    chk("f5_beats", 32'(beat_q.size() - nb), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("f5_b%0d", i), 32'(beat_q[nb+i]), {22'd0, (i == 0), (i == 7), 8'(i + 1)});
    chk("f5_stall",  32'(stall_viol), 32'd0);
    chk("f5_hold",   32'(hold_viol),  32'd0);
    chk("f5_okp",    32'(ok_pulses - ok0), 32'd1);
    chk("f5_ok_cnt", 32'(ok_cnt), 32'd4);

    // Reset after the 2nd payload byte of a len=5 frame.
    ok0 = ok_pulses; err0 = err_pulses;
    push(8'h55, 0); push(8'hAA, 0); push(8'h05, 0);
    push(8'hA1, 0); push(8'hA2, 0);
    rd_rst = 1'b1;
    idle(2);
    chk("r_m_valid", 32'(m_valid), 32'd0);
    chk("r_ok_cnt",  32'(ok_cnt),  32'd0);
    chk("r_err_cnt", 32'(err_cnt), 32'd0);
    rd_rst = 1'b0;
    chk("r_rd_en", 32'(in_rd_en), 32'd1);
    idle(3);
    chk("r_no_pulse", 32'((ok_pulses - ok0) + (err_pulses - err0)), 32'd0);
    nb = beat_q.size();
    push(8'h55, 0); push(8'hAA, 0); push(8'h03, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    push(8'h03, 0);
    chk("r_ok_pulse", 32'(frame_ok), 32'd1);
    idle(4);
    chk("r_beats",  32'(beat_q.size() - nb), 32'd3);
    chk("r_ok_cnt2", 32'(ok_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
